// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and helpers for the multi-port register file
package regfile_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// rtl/regfile_clear_fsm.sv - sequential zeroing sweep controller for the register file
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_req,
  output logic          clear_busy,
  output logic [AW-1:0] clear_idx
);

  logic [0:0]    state;
  logic [AW-1:0] ptr;

  // clear_req is only looked at in IDLE, so repeated pulses mid-sweep are ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else if (state == ST_IDLE) begin
      if (clear_req) begin
        state <= ST_CLEAR;
        ptr   <= '0;
      end
    end else begin
      ptr <= ptr + AW'(1);
      if (ptr == AW'(DEPTH - 1)) state <= ST_IDLE;
    end
  end

  assign clear_busy = (state == ST_CLEAR);
  assign clear_idx  = ptr;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with bypass and clear sweep
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = addr_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WR_PORTS-1:0]      regwrite,
  input  logic [WR_PORTS*AW-1:0]   rd,
  input  logic [WR_PORTS*XLEN-1:0] write_data,
  input  logic [RD_PORTS*AW-1:0]   rs,
  output logic [RD_PORTS*XLEN-1:0] read_data,
  input  logic                     clear_req,
  output logic                     clear_busy,
  output logic                     wr_ready
);

  logic [XLEN-1:0]     mem [DEPTH];
  logic [WR_PORTS-1:0] accept;
  logic [AW-1:0]       clear_idx;

  regfile_clear_fsm #(.DEPTH(DEPTH), .AW(AW)) u_clear_fsm (
    .clk        (clk),
    .reset      (reset),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .clear_idx  (clear_idx)
  );

  assign wr_ready = !clear_busy;

  for (genvar p = 0; p < WR_PORTS; p++) begin : g_accept
    assign accept[p] = regwrite[p] && wr_ready &&
                       !((ZERO_REG != 0) && (rd[p*AW +: AW] == '0));
  end

  // Later ports overwrite earlier ones in the loop, so the highest index wins a conflict
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear_busy) begin
      mem[clear_idx] <= '0;
    end else begin
      for (int p = 0; p < WR_PORTS; p++)
        if (accept[p]) mem[rd[p*AW +: AW]] <= write_data[p*XLEN +: XLEN];
    end
  end

  for (genvar q = 0; q < RD_PORTS; q++) begin : g_read
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] val;

    assign idx = rs[q*AW +: AW];

    always_comb begin
      val = mem[idx];
      if ((BYPASS != 0) && !clear_busy)
        for (int p = 0; p < WR_PORTS; p++)
          if (accept[p] && (rd[p*AW +: AW] == idx)) val = write_data[p*XLEN +: XLEN];
      if ((ZERO_REG != 0) && (idx == '0)) val = '0;
    end

    assign read_data[q*XLEN +: XLEN] = val;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized and directed checks of regfile_mp against a reference model
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  regwrite;
  logic [9:0]  rd;
  logic [63:0] wdata;
  logic [9:0]  rs;
  logic        clear_req;
  logic [63:0] rdata_a, rdata_b;
  logic        busy_a, busy_b, ready_a, ready_b;

  logic         regwrite16;
  logic [3:0]   rd16;
  logic [31:0]  wdata16;
  logic [15:0]  rs16;
  logic         clear_req16;
  logic [127:0] rdata16;
  logic         busy16, ready16;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_a [32];
  bit          act_a;
  int          pos_a;
  logic [31:0] m16 [16];
  bit          act16;
  int          pos16;

  always #5 clk = ~clk;

  regfile_mp u_dut (
    .clk(clk), .reset(reset), .regwrite(regwrite), .rd(rd), .write_data(wdata),
    .rs(rs), .read_data(rdata_a), .clear_req(clear_req), .clear_busy(busy_a), .wr_ready(ready_a)
  );

  regfile_mp #(.BYPASS(0)) u_nobyp (
    .clk(clk), .reset(reset), .regwrite(regwrite), .rd(rd), .write_data(wdata),
    .rs(rs), .read_data(rdata_b), .clear_req(clear_req), .clear_busy(busy_b), .wr_ready(ready_b)
  );

  regfile_mp #(.DEPTH(16), .RD_PORTS(4), .WR_PORTS(1)) u_d16 (
    .clk(clk), .reset(reset), .regwrite(regwrite16), .rd(rd16), .write_data(wdata16),
    .rs(rs16), .read_data(rdata16), .clear_req(clear_req16), .clear_busy(busy16), .wr_ready(ready16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_read_a(input int q, input bit byp);
    logic [4:0]  idx;
    logic [31:0] r;
    idx = rs[q*5 +: 5];
    if (idx == 5'd0) return 32'd0;
    r = m_a[idx];
    if (byp && !act_a)
      for (int p = 0; p < 2; p++)
        if (regwrite[p] && rd[p*5 +: 5] == idx) r = wdata[p*32 +: 32];
    return r;
  endfunction

  function automatic logic [31:0] exp_read16(input int q);
    logic [3:0] idx;
    idx = rs16[q*4 +: 4];
    if (idx == 4'd0) return 32'd0;
    if (!act16 && regwrite16 && rd16 == idx) return wdata16;
    return m16[idx];
  endfunction

  task automatic update_models();
    if (reset) begin
      for (int i = 0; i < 32; i++) m_a[i] = 32'd0;
      for (int i = 0; i < 16; i++) m16[i] = 32'd0;
      act_a = 1'b0;
      act16 = 1'b0;
    end else begin
      if (act_a) begin
        m_a[pos_a] = 32'd0;
        pos_a++;
        if (pos_a == 32) act_a = 1'b0;
      end else begin
        for (int p = 0; p < 2; p++)
          if (regwrite[p] && rd[p*5 +: 5] != 5'd0) m_a[rd[p*5 +: 5]] = wdata[p*32 +: 32];
        if (clear_req) begin
          act_a = 1'b1;
          pos_a = 0;
        end
      end
      if (act16) begin
        m16[pos16] = 32'd0;
        pos16++;
        if (pos16 == 16) act16 = 1'b0;
      end else begin
        if (regwrite16 && rd16 != 4'd0) m16[rd16] = wdata16;
        if (clear_req16) begin
          act16 = 1'b1;
          pos16 = 0;
        end
      end
    end
  endtask

  // Caller sets default-config inputs; the 16-entry instance gets fresh random stimulus each cycle
  task automatic cycle();
    regwrite16  = 1'($urandom_range(0, 1));
    rd16        = 4'($urandom);
    wdata16     = $urandom;
    rs16        = 16'($urandom);
    if ($urandom_range(0, 2) == 0) rs16[3:0] = rd16;
    clear_req16 = ($urandom_range(0, 39) == 0);
    @(negedge clk);
    for (int q = 0; q < 2; q++) begin
      check("read_byp", rdata_a[q*32 +: 32], exp_read_a(q, 1'b1));
      check("read_nobyp", rdata_b[q*32 +: 32], exp_read_a(q, 1'b0));
    end
    check("clear_busy", 32'(busy_a), 32'(act_a));
    check("wr_ready", 32'(ready_a), 32'(!act_a));
    check("clear_busy_nobyp", 32'(busy_b), 32'(act_a));
    for (int q = 0; q < 4; q++) check("read16", rdata16[q*32 +: 32], exp_read16(q));
    check("clear_busy16", 32'(busy16), 32'(act16));
    check("wr_ready16", 32'(ready16), 32'(!act16));
    @(posedge clk);
    update_models();
    #1;
  endtask

  task automatic idle_in();
    reset     = 1'b0;
    regwrite  = '0;
    rd        = '0;
    wdata     = '0;
    rs        = '0;
    clear_req = 1'b0;
  endtask

  task automatic read_all();
    idle_in();
    for (int i = 0; i < 32; i += 2) begin
      rs = {5'(i + 1), 5'(i)};
      cycle();
    end
  endtask

  initial begin
    act_a = 1'b0; pos_a = 0; act16 = 1'b0; pos16 = 0;
    for (int i = 0; i < 32; i++) m_a[i] = 32'hx;
    for (int i = 0; i < 16; i++) m16[i] = 32'hx;
    idle_in();
    reset = 1'b1;
    #1;
    @(posedge clk);
    update_models();
    #1;
    idle_in();
    cycle();

    // reset after a write, with a same-cycle write that reset must beat
    regwrite = 2'b01; rd = {5'd0, 5'd5}; wdata = {32'd0, 32'hDEADBEEF}; rs = {5'd0, 5'd5};
    cycle();
    reset = 1'b1; regwrite = 2'b10; rd = {5'd6, 5'd0}; wdata = {32'h1234, 32'd0};
    cycle();
    idle_in(); rs = {5'd6, 5'd5};
    cycle();

    // same-rd conflict, then write to x0
    regwrite = 2'b11; rd = {5'd7, 5'd7}; wdata = {32'h22, 32'h11}; rs = {5'd0, 5'd7};
    cycle();
    idle_in(); rs = {5'd0, 5'd7};
    cycle();
    regwrite = 2'b01; rd = {5'd0, 5'd0}; wdata = {32'd0, 32'hFFFF_FFFF}; rs = {5'd7, 5'd0};
    cycle();
    idle_in(); rs = {5'd7, 5'd0};
    cycle();

    // bypass vs. old value
    regwrite = 2'b01; rd = {5'd0, 5'd3}; wdata = {32'd0, 32'hA5A5A5A5}; rs = {5'd3, 5'd3};
    cycle();
    idle_in(); rs = {5'd0, 5'd3};
    cycle();

    // fill, sweep with dropped writes and ignored clear_req, read back
    for (int i = 1; i < 32; i += 2) begin
      idle_in();
      regwrite = 2'b11;
      rd = {5'(i + 1), 5'(i)};
      wdata = {32'(i + 1), 32'(i)};
      cycle();
    end
    idle_in(); clear_req = 1'b1; rs = {5'd4, 5'd31};
    cycle();
    for (int k = 0; k < 34; k++) begin
      idle_in();
      regwrite = 2'b01; rd = {5'd0, 5'd4}; wdata = {32'd0, 32'h99};
      rs = {5'(k), 5'd31};
      clear_req = (k == 5);
      cycle();
    end
    read_all();

    // clear_req with same-cycle write, then reset mid-sweep
    idle_in(); regwrite = 2'b01; rd = {5'd0, 5'd9}; wdata = {32'd0, 32'h55}; clear_req = 1'b1;
    rs = {5'd0, 5'd9};
    cycle();
    for (int k = 0; k < 10; k++) begin
      idle_in(); rs = {5'(k), 5'd9};
      cycle();
    end
    idle_in(); reset = 1'b1;
    cycle();
    read_all();

    // randomized traffic with collisions, bypass hits, sweeps and occasional reset
    for (int n = 0; n < 1500; n++) begin
      idle_in();
      regwrite = 2'($urandom);
      for (int p = 0; p < 2; p++)
        rd[p*5 +: 5] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wdata = {$urandom, $urandom};
      rs = 10'($urandom);
      if ($urandom_range(0, 2) == 0) rs[4:0] = rd[($urandom_range(0, 1))*5 +: 5];
      clear_req = ($urandom_range(0, 59) == 0);
      reset = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
